// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   - access variant encodings carried in func[2:1]
//   - arbiter FSM state type
//   - default memory size in bytes
// Ports: none (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] VAR_BYTE_U = 2'b00;
    localparam logic [1:0] VAR_BYTE_S = 2'b01;
    localparam logic [1:0] VAR_WORD   = 2'b10;

    localparam int MEM_BYTES_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // The access variant lives in bits [2:1]; bits 3 and 0 are passed to
    // the memory untouched.
    function automatic logic [1:0] func_variant(input logic [3:0] func);
        return func[2:1];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports, both response ports and the memory-side
// signals of the data-memory arbiter.
//   rqN_*   : request valid/ready, wr, func, addr, wdata (N = 0 CPU, 1 debug)
//   rspN_*  : response valid/ready, rdata, err
//   mem_*   : memory enable, write, func, addr, wdata, rdata, wb_sel
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters + memory)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              rq0_valid, rq1_valid;
    logic              rq0_ready, rq1_ready;
    logic              rq0_wr,    rq1_wr;
    logic [3:0]        rq0_func,  rq1_func;
    logic [ADDR_W-1:0] rq0_addr,  rq1_addr;
    logic [DATA_W-1:0] rq0_wdata, rq1_wdata;

    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              rsp0_err,   rsp1_err;

    logic              mem_en;
    logic              mem_wr;
    logic [3:0]        mem_func;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wb_sel;

    modport slave (
        input  rq0_valid, rq1_valid, rq0_wr, rq1_wr, rq0_func, rq1_func,
               rq0_addr, rq1_addr, rq0_wdata, rq1_wdata,
               rsp0_ready, rsp1_ready, mem_rdata, mem_wb_sel,
        output rq0_ready, rq1_ready,
               rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
               mem_en, mem_wr, mem_func, mem_addr, mem_wdata
    );

    modport master (
        output rq0_valid, rq1_valid, rq0_wr, rq1_wr, rq0_func, rq1_func,
               rq0_addr, rq1_addr, rq0_wdata, rq1_wdata,
               rsp0_ready, rsp1_ready, mem_rdata, mem_wb_sel,
        input  rq0_ready, rq1_ready,
               rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
               mem_en, mem_wr, mem_func, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_req_check.sv
// ---------------------------------------------------------------------------
// dmem_req_check
// Combinational legality check of one request.
// Ports:
//   wr      in  1 = store, 0 = load
//   variant in  access variant (func[2:1])
//   addr    in  byte address
//   legal   out request may access memory
//   err     out request is rejected (inverse of legal)
// Rejected: addr beyond memory, variant 11, signed-byte store, and a word
// access on the last byte (no wrap-around).
// ---------------------------------------------------------------------------
module dmem_req_check
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              wr,
    input  logic [1:0]        variant,
    input  logic [ADDR_W-1:0] addr,
    output logic              legal,
    output logic              err
);
    // One extra bit so MEM_BYTES itself is representable even when it
    // equals 2**ADDR_W.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(MEM_BYTES - 1);

    logic [ADDR_W:0] addr_x;
    assign addr_x = {1'b0, addr};

    always_comb begin
        legal = 1'b1;
        if (addr_x >= LIMIT)                          legal = 1'b0;
        if (variant == 2'b11)                         legal = 1'b0;
        if (wr && (variant == VAR_BYTE_S))            legal = 1'b0;
        if ((variant == VAR_WORD) && (addr_x == LAST)) legal = 1'b0;
        err = ~legal;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port byte-addressable data memory between the CPU MEM
// stage (port 0) and a debug/loader port (port 1). One access at a time:
// IDLE (accept) -> ACCESS (1 cycle on the memory) -> RESP (hold until taken).
// Rejected requests skip ACCESS and respond with err=1, rdata=0.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave: requests, responses, memory signals
// Build option:
//   DMEM_ARB_RR_EN defined   - round-robin between simultaneous requests
//   DMEM_ARB_RR_EN undefined - fixed priority, port 0 wins
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    state_t            state, state_nxt;
    logic              owner;
    logic              sel;
    logic              any_valid;
    logic              sel_wr;
    logic [3:0]        sel_func;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              legal, sel_err;
    logic              rsp_fire;

    logic              mem_en_r, mem_wr_r;
    logic [3:0]        mem_func_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    assign any_valid = bus.rq0_valid | bus.rq1_valid;
    assign rsp_fire  = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    // Pointer moves to the other port when a transaction completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        rr_ptr <= 1'b0;
        else if (rsp_fire) rr_ptr <= ~owner;
    end

    assign sel = (bus.rq0_valid && bus.rq1_valid) ? rr_ptr : bus.rq1_valid;
`else
    // Port 1 is picked only when port 0 has nothing pending.
    assign sel = ~bus.rq0_valid;
`endif

    assign sel_wr    = sel ? bus.rq1_wr    : bus.rq0_wr;
    assign sel_func  = sel ? bus.rq1_func  : bus.rq0_func;
    assign sel_addr  = sel ? bus.rq1_addr  : bus.rq0_addr;
    assign sel_wdata = sel ? bus.rq1_wdata : bus.rq0_wdata;

    dmem_req_check #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .wr      (sel_wr),
        .variant (func_variant(sel_func)),
        .addr    (sel_addr),
        .legal   (legal),
        .err     (sel_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ready is gated by reset so nothing is accepted while it is asserted.
    always_comb begin
        state_nxt     = state;
        bus.rq0_ready = 1'b0;
        bus.rq1_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.rq0_ready = reset && bus.rq0_valid && !sel;
                bus.rq1_ready = reset && bus.rq1_valid &&  sel;
                if (any_valid) state_nxt = legal ? ACCESS : RESP;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch in IDLE, read capture at the end of ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_func_r  <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner     <= sel;
                        rsp_rdata <= '0;
                        rsp_err   <= sel_err;
                        if (legal) begin
                            mem_en_r    <= 1'b1;
                            mem_wr_r    <= sel_wr;
                            mem_func_r  <= sel_func;
                            mem_addr_r  <= sel_addr;
                            mem_wdata_r <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_en_r <= 1'b0;
                    if (!mem_wr_r) begin
                        // A load must be flagged by the memory as a write-back.
                        if (bus.mem_wb_sel) rsp_rdata <= bus.mem_rdata;
                        else                rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_func  = mem_func_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) &&  owner;
    assign bus.rsp0_rdata = bus.rsp0_valid ? rsp_rdata : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? rsp_rdata : '0;
    assign bus.rsp0_err   = bus.rsp0_valid && rsp_err;
    assign bus.rsp1_err   = bus.rsp1_valid && rsp_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Testbench for dmem_arbiter: drives both requester ports, plays the
// 256-byte memory, and compares responses with a transaction-level model
// (expected byte contents + legality rules + arbitration order).
// Honours DMEM_ARB_RR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_BYTES(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];
    logic       force_wb_bad;
    int         mem_en_cnt = 0;
    int         ptr_model;
    logic [7:0] rd_a;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 5) ^ (i >> 3));
    endfunction

    // Memory device: store at the clock edge, combinational read.
    initial begin : device
        logic [7:0] a;
        for (int i = 0; i < 256; i++) dev_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (bus.mem_en && bus.mem_wr) begin
                a = bus.mem_addr[7:0];
                dev_mem[a] = bus.mem_wdata[7:0];
                if (bus.mem_func[2:1] == 2'b10) dev_mem[8'(a + 8'd1)] = bus.mem_wdata[15:8];
            end
        end
    end

    assign rd_a = bus.mem_addr[7:0];

    always_comb begin
        case (bus.mem_func[2:1])
            2'b00:   bus.mem_rdata = {8'h00, dev_mem[rd_a]};
            2'b01:   bus.mem_rdata = {{8{dev_mem[rd_a][7]}}, dev_mem[rd_a]};
            default: bus.mem_rdata = {dev_mem[8'(rd_a + 8'd1)], dev_mem[rd_a]};
        endcase
        bus.mem_wb_sel = bus.mem_en && !bus.mem_wr && !force_wb_bad;
    end

    always @(posedge clk) if (bus.mem_en) mem_en_cnt <= mem_en_cnt + 1;

    // ---------------- reference model ----------------
    function automatic logic model_legal(input logic wr, input logic [3:0] func, input logic [15:0] addr);
        logic [1:0] v;
        v = func[2:1];
        if (addr >= 16'd256)               return 1'b0;
        if (v == 2'b11)                    return 1'b0;
        if (wr && v == 2'b01)              return 1'b0;
        if (v == 2'b10 && addr == 16'd255) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_load(input logic [3:0] func, input logic [15:0] addr);
        int a;
        a = int'(addr[7:0]);
        case (func[2:1])
            2'b00:   return 16'(ref_mem[a]);
            2'b01:   return 16'(int'(ref_mem[a]) - (ref_mem[a][7] ? 256 : 0));
            default: return 16'(int'(ref_mem[a]) + 256 * int'(ref_mem[(a + 1) % 256]));
        endcase
    endfunction

    task automatic model_store(input logic [3:0] func, input logic [15:0] addr, input logic [15:0] wdata);
        int a;
        a = int'(addr[7:0]);
        ref_mem[a] = wdata[7:0];
        if (func[2:1] == 2'b10) ref_mem[(a + 1) % 256] = wdata[15:8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int p, input logic v, input logic wr, input logic [3:0] func,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (p == 0) begin
            bus.rq0_valid = v; bus.rq0_wr = wr; bus.rq0_func = func;
            bus.rq0_addr = addr; bus.rq0_wdata = wdata;
        end else begin
            bus.rq1_valid = v; bus.rq1_wr = wr; bus.rq1_func = func;
            bus.rq1_addr = addr; bus.rq1_wdata = wdata;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) bus.rsp0_ready = v;
        else        bus.rsp1_ready = v;
    endtask

    function automatic logic rsp_valid_of(input int p);
        return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    // One complete transaction on port p, entered and left #1 after a clock edge.
    task automatic do_txn(input int p, input logic wr, input logic [3:0] func,
                          input logic [15:0] addr, input logic [15:0] wdata, input string nm);
        logic        legal, exp_err, got;
        logic [15:0] exp_rd, rd;
        logic        er;
        int          en0;
        legal   = model_legal(wr, func, addr);
        exp_err = !legal || (!wr && force_wb_bad);
        exp_rd  = (legal && !wr && !force_wb_bad) ? model_load(func, addr) : 16'h0000;
        en0     = mem_en_cnt;
        set_req(p, 1'b1, wr, func, addr, wdata);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? bus.rq0_ready : bus.rq1_ready;
            @(posedge clk); #1;
        end
        set_req(p, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s accept: ready not seen in 20 cycles, required 1", nm);
            return;
        end
        checks++;
        if (rsp_valid_of(p) !== !legal) begin
            errors++;
            $display("FAIL %s rsp_valid one cycle after accept: got %b required %b", nm, rsp_valid_of(p), !legal);
        end
        checks++;
        if (bus.mem_en !== legal) begin
            errors++;
            $display("FAIL %s mem_en in access cycle: got %b required %b", nm, bus.mem_en, legal);
        end
        if (legal) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid_of(p) !== 1'b1) begin
                errors++;
                $display("FAIL %s rsp_valid two cycles after accept: got %b required 1", nm, rsp_valid_of(p));
            end
        end
        rd = (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
        er = (p == 0) ? bus.rsp0_err   : bus.rsp1_err;
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", nm, rd, exp_rd);
        end
        checks++;
        if (er !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", nm, er, exp_err);
        end
        set_rsp_ready(p, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(p, 1'b0);
        checks++;
        if (mem_en_cnt - en0 != (legal ? 1 : 0)) begin
            errors++;
            $display("FAIL %s mem_en cycles: got %0d required %0d", nm, mem_en_cnt - en0, legal ? 1 : 0);
        end
        checks++;
        if (rsp_valid_of(p) !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_valid after consume: got %b required 0", nm, rsp_valid_of(p));
        end
        if (legal && wr) model_store(func, addr, wdata);
        ptr_model = 1 - p;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'h4, 16'h0010, 16'h0000);
        set_req(1, 1'b1, 1'b0, 4'h0, 16'h0020, 16'h0000);
        #7;
        checks++;
        if ({bus.rq0_ready, bus.rq1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset ready: got %b required 00", {bus.rq0_ready, bus.rq1_ready});
        end
        checks++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset mem outputs: got en=%b wr=%b addr=%h wdata=%h required all 0",
                     bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err, bus.rsp0_rdata, bus.rsp1_rdata} !== 36'd0) begin
            errors++;
            $display("FAIL reset rsp outputs: got v=%b%b e=%b%b rd0=%h rd1=%h required all 0",
                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err, bus.rsp0_rdata, bus.rsp1_rdata);
        end
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        ptr_model = 0;
    endtask

    task automatic test_store_load_word;
        do_txn(0, 1'b1, 4'b0100, 16'h0010, 16'h1234, "sw0x1234");
        do_txn(0, 1'b0, 4'b0100, 16'h0010, 16'h0000, "lw@10");
    endtask

    task automatic test_byte_ext;
        do_txn(1, 1'b1, 4'b0000, 16'h0020, 16'h0080, "sb0x80");
        do_txn(1, 1'b0, 4'b0010, 16'h0020, 16'h0000, "lbs@20");
        do_txn(1, 1'b0, 4'b0000, 16'h0020, 16'h0000, "lbu@20");
    endtask

    task automatic test_illegal;
        do_txn(0, 1'b0, 4'b0100, 16'h00FF, 16'h0000, "word@FF");
        do_txn(1, 1'b0, 4'b0000, 16'h0100, 16'h0000, "addr100");
        do_txn(0, 1'b1, 4'b0010, 16'h0040, 16'h5555, "store_v01");
        do_txn(1, 1'b0, 4'b0110, 16'h0008, 16'h0000, "var11");
        do_txn(0, 1'b0, 4'b0000, 16'h00FF, 16'h0000, "byte@FF");
        do_txn(1, 1'b1, 4'b0100, 16'h00FE, 16'hA55A, "sw@FE");
        do_txn(0, 1'b0, 4'b0100, 16'h00FE, 16'h0000, "lw@FE");
    endtask

    task automatic test_wb_sel;
        force_wb_bad = 1'b1;
        do_txn(0, 1'b0, 4'b0100, 16'h0010, 16'h0000, "wbsel_bad");
        force_wb_bad = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [15:0] exp0, exp1;
        logic        got;
        exp0 = model_load(4'b0100, 16'h0010);
        exp1 = model_load(4'b0000, 16'h0020);
        set_req(0, 1'b1, 1'b0, 4'b0100, 16'h0010, 16'h0000);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.rq0_ready;
            @(posedge clk); #1;
        end
        set_req(0, RR_EN, 1'b0, 4'b0100, 16'h0010, 16'h0000);
        set_req(1, 1'b1, 1'b0, 4'b0000, 16'h0020, 16'h0000);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp accept: ready not seen in 20 cycles, required 1");
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== exp0) begin
                errors++;
                $display("FAIL bp hold %0d: got valid=%b rdata=%h required valid=1 rdata=%h",
                         i, bus.rsp0_valid, bus.rsp0_rdata, exp0);
            end
            checks++;
            if (bus.rq1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp hold %0d rq1_ready: got %b required 0", i, bus.rq1_ready);
            end
            @(posedge clk); #1;
        end
        bus.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        ptr_model = 1;
        @(negedge clk);
        checks++;
        if ({bus.rq0_ready, bus.rq1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp next grant: got rq0_ready=%b rq1_ready=%b required 0 1", bus.rq0_ready, bus.rq1_ready);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_rdata !== exp1) begin
            errors++;
            $display("FAIL bp port1 rsp: got valid=%b rdata=%h required valid=1 rdata=%h",
                     bus.rsp1_valid, bus.rsp1_rdata, exp1);
        end
        bus.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b0;
        ptr_model = 0;
    endtask

    task automatic test_grants;
        int   n, expw;
        logic r0, r1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'b0000, 16'h0040, 16'h0000);
        set_req(1, 1'b1, 1'b0, 4'b0010, 16'h0041, 16'h0000);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            r0 = bus.rq0_ready;
            r1 = bus.rq1_ready;
            if (r0 || r1) begin
                expw = RR_EN ? ptr_model : 0;
                checks++;
                if ((r0 && r1) || (r1 ? 1 : 0) != expw) begin
                    errors++;
                    $display("FAIL grant %0d: got ready0=%b ready1=%b required port %0d", n, r0, r1, expw);
                end
                ptr_model = r1 ? 0 : 1;
                n++;
            end
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL grants count: got %0d in 40 cycles required 4", n);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
            errors++;
            $display("FAIL grants drain: got rsp_valid=%b%b required 00", bus.rsp0_valid, bus.rsp1_valid);
        end
    endtask

    task automatic test_random;
        int          p, sel;
        logic        wr;
        logic [3:0]  func;
        logic [15:0] addr, wdata;
        for (int k = 0; k < 40; k++) begin
            p     = int'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            func  = 4'($urandom);
            wdata = 16'($urandom);
            sel   = int'($urandom_range(0, 9));
            case (sel)
                0:       addr = 16'h00FF;
                1:       addr = 16'(256 + $urandom_range(0, 300));
                2:       addr = 16'($urandom);
                default: addr = 16'($urandom_range(0, 255));
            endcase
            do_txn(p, wr, func, addr, wdata, "rand");
        end
    endtask

    task automatic test_reset_mid_store;
        logic got;
        do_txn(0, 1'b0, 4'b0100, 16'h0030, 16'h0000, "lw@30_before");
        set_req(0, 1'b1, 1'b1, 4'b0100, 16'h0030, 16'hBEEF);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.rq0_ready;
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        checks++;
        if (!got || bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid accept: got accepted=%b mem_en=%b required 1 1", got, bus.mem_en);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_en !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async drop: got mem_en=%b rsp0_valid=%b required 0 0", bus.mem_en, bus.rsp0_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        ptr_model = 0;
        set_req(0, 1'b1, 1'b0, 4'b0100, 16'h0030, 16'h0000);
        set_req(1, 1'b1, 1'b0, 4'b0100, 16'h0030, 16'h0000);
        @(negedge clk);
        checks++;
        if ({bus.rq0_ready, bus.rq1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid pointer: got rq0_ready=%b rq1_ready=%b required 1 0", bus.rq0_ready, bus.rq1_ready);
        end
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        do_txn(0, 1'b0, 4'b0100, 16'h0030, 16'h0000, "lw@30_after_rst");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        force_wb_bad   = 1'b0;
        ptr_model      = 0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        set_req(0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        test_reset();
        test_store_load_word();
        test_byte_ext();
        test_illegal();
        test_wb_sel();
        test_backpressure();
        test_grants();
        test_random();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
